pb_card_responder: RTL and testbench

PB_CARD_RESPONDER -- requirements
Module: pb_card_responder

---
 rtl/pb_card_responder_pkg.sv | 47 ++++
 rtl/pb_sync2.sv | 33 +++
 rtl/pb_card_responder.sv | 208 ++++++++++++++++++++
 tb/tb_pb_card_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_card_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pb_card_responder_pkg
// Brief    : Shared types and constants for the parallel-bus card responder.
// Revision : 1.0 - initial release
// ============================================================================
package pb_card_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WR_HOLD = 3'd2,
        ST_READ    = 3'd3,
        ST_TEST    = 3'd4
    } state_t;

    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_mode_t;

    // Bus strobes are active low.
    typedef enum logic {
        EN_ENABLE  = 1'b0,
        EN_DISABLE = 1'b1
    } en_mode_t;

    localparam logic [2:0] c_ADDR_REG0   = 3'd0;
    localparam logic [2:0] c_ADDR_REG1   = 3'd1;
    localparam logic [2:0] c_ADDR_REG2   = 3'd2;
    localparam logic [2:0] c_ADDR_REG3   = 3'd3;
    localparam logic [2:0] c_ADDR_REG4   = 3'd4;
    localparam logic [2:0] c_ADDR_ADC_LO = 3'd5;
    localparam logic [2:0] c_ADDR_ADC_HI = 3'd6;
    localparam logic [2:0] c_ADDR_STATUS = 3'd7;

    localparam int unsigned c_NUM_STORE = 5;

    localparam logic [3:0] c_BOARD_ALL = 4'hF;
    localparam logic [3:0] c_NO_BOARD  = 4'h0;

    function automatic logic is_storage(input logic [2:0] addr);
        return (addr <= c_ADDR_REG4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pb_sync2.sv
`default_nettype none
// ============================================================================
// Module   : pb_sync2
// Brief    : Two-flop synchronizer with a parameterised reset value.
// Revision : 1.0 - initial release
// ============================================================================
module pb_sync2 #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pb_card_responder.sv
`default_nettype none
// ============================================================================
// Module   : pb_card_responder
// Brief    : Parallel-bus card: 5 byte registers, card-ID test cycle and a
//            timed ADC conversion with status/result readback.
// Revision : 1.0 - initial release
// ============================================================================
module pb_card_responder
    import pb_card_responder_pkg::*;
#(
    parameter int unsigned CARD_INDEX      = 0,
    parameter logic [7:0]  CARD_ID         = 8'hA0,
    parameter int unsigned ADC_CONV_CYCLES = 540
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  BOARD_X,
    input  logic [2:0]  AddessPort,
    input  logic        PB_RD,
    input  logic        PB_WR,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    input  logic [15:0] adc_sample_in,
    output logic [31:0] out_regs,
    output logic        write_pulse,
    output logic        adc_busy
);

    localparam int unsigned      c_CNT_W    = (ADC_CONV_CYCLES > 1) ? $clog2(ADC_CONV_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ADC_CONV_CYCLES - 1);
    localparam logic [1:0]       c_SEL_BIT  = CARD_INDEX[1:0];

    logic [3:0] w_board_s;
    logic [2:0] w_addr_s;
    logic       w_rd_s;
    logic       w_wr_s;

    pb_sync2 #(.WIDTH(4), .RESET_VAL(c_NO_BOARD)) u_sync_board (
        .clock (clock),
        .reset (reset),
        .i_d   (BOARD_X),
        .o_q   (w_board_s)
    );

    pb_sync2 #(.WIDTH(3), .RESET_VAL(3'b000)) u_sync_addr (
        .clock (clock),
        .reset (reset),
        .i_d   (AddessPort),
        .o_q   (w_addr_s)
    );

    pb_sync2 #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_rd (
        .clock (clock),
        .reset (reset),
        .i_d   (PB_RD),
        .o_q   (w_rd_s)
    );

    pb_sync2 #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_wr (
        .clock (clock),
        .reset (reset),
        .i_d   (PB_WR),
        .o_q   (w_wr_s)
    );

    state_t             r_state;
    dir_mode_t          r_dir;
    logic [7:0]         r_data_out;
    logic               r_write_pulse;
    logic [7:0]         r_regs [c_NUM_STORE];
    logic               r_wr_armed;
    logic [c_CNT_W-1:0] r_adc_cnt;
    logic               r_adc_busy;
    logic [15:0]        r_adc_result;

    logic       w_sel;
    logic       w_rd_en;
    logic       w_wr_en;
    logic       w_go_test;
    logic       w_go_write;
    logic       w_go_read;
    logic       w_take_write;
    logic       w_adc_start;
    logic [7:0] w_rd_mux;
    logic       w_unused_board;

    assign w_sel          = w_board_s[c_SEL_BIT];
    assign w_unused_board = ^w_board_s;
    assign w_rd_en        = (w_rd_s == EN_ENABLE);
    assign w_wr_en        = (w_wr_s == EN_ENABLE);

    assign w_go_test    = w_sel & w_rd_en & w_wr_en;
    assign w_go_write   = w_sel & w_wr_en & ~w_rd_en & r_wr_armed;
    assign w_go_read    = w_sel & w_rd_en & ~w_wr_en;
    assign w_take_write = (r_state == ST_IDLE) & w_go_write;
    assign w_adc_start  = w_take_write & (w_addr_s == c_ADDR_STATUS);

    always_comb begin
        w_rd_mux = '0;
        case (w_addr_s)
            c_ADDR_ADC_LO: w_rd_mux = r_adc_result[7:0];
            c_ADDR_ADC_HI: w_rd_mux = r_adc_result[15:8];
            c_ADDR_STATUS: w_rd_mux = {7'b0, r_adc_busy};
            default:       w_rd_mux = r_regs[w_addr_s];
        endcase
    end

    // A write is only allowed after WR has been seen released, so a strobe
    // held across TEST exit, sel changes or reset release cannot fire one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_armed <= 1'b0;
        end else if (!w_wr_en) begin
            r_wr_armed <= 1'b1;
        end else if (!w_sel || w_take_write || ((r_state == ST_IDLE) && w_go_test)) begin
            r_wr_armed <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_dir         <= DIR_IN;
            r_data_out    <= '0;
            r_write_pulse <= 1'b0;
            for (int i = 0; i < c_NUM_STORE; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_write_pulse <= 1'b0;
            r_dir         <= DIR_IN;
            r_data_out    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go_test) begin
                        r_state    <= ST_TEST;
                        r_dir      <= DIR_OUT;
                        r_data_out <= CARD_ID;
                    end else if (w_go_write) begin
                        // Data is captured on entry, so it is visible for the whole WRITE cycle.
                        r_state       <= ST_WRITE;
                        r_write_pulse <= 1'b1;
                        if (is_storage(w_addr_s)) begin
                            r_regs[w_addr_s] <= bus_data_in;
                        end
                    end else if (w_go_read) begin
                        r_state    <= ST_READ;
                        r_dir      <= DIR_OUT;
                        r_data_out <= w_rd_mux;
                    end
                end
                ST_WRITE: begin
                    r_state <= w_sel ? ST_WR_HOLD : ST_IDLE;
                end
                ST_WR_HOLD: begin
                    if (!w_wr_en || !w_sel) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (!w_rd_en || !w_sel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dir      <= DIR_OUT;
                        r_data_out <= w_rd_mux;
                    end
                end
                ST_TEST: begin
                    if (!w_rd_en || !w_wr_en || !w_sel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dir      <= DIR_OUT;
                        r_data_out <= CARD_ID;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Conversion timer: a new start always reloads, even mid-conversion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_adc_cnt    <= '0;
            r_adc_busy   <= 1'b0;
            r_adc_result <= '0;
        end else if (w_adc_start) begin
            r_adc_cnt  <= c_CNT_LOAD;
            r_adc_busy <= 1'b1;
        end else if (r_adc_busy) begin
            if (r_adc_cnt == '0) begin
                r_adc_result <= adc_sample_in;
                r_adc_busy   <= 1'b0;
            end else begin
                r_adc_cnt <= r_adc_cnt - 1'b1;
            end
        end
    end

    assign bus_data_out = r_data_out;
    assign bus_data_oe  = (r_dir == DIR_OUT);
    assign write_pulse  = r_write_pulse;
    assign adc_busy     = r_adc_busy;
    assign out_regs     = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};

endmodule
`default_nettype wire

// File: tb/tb_pb_card_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pb_card_responder
// Brief    : Directed, table-driven bench for pb_card_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_card_responder;
    import pb_card_responder_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  board;
    logic [2:0]  addr;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic [15:0] adc_sample;
    logic [31:0] out_regs;
    logic        wpulse;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    pb_card_responder #(
        .CARD_INDEX      (0),
        .CARD_ID         (8'hA0),
        .ADC_CONV_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .BOARD_X       (board),
        .AddessPort    (addr),
        .PB_RD         (rd_n),
        .PB_WR         (wr_n),
        .bus_data_in   (din),
        .bus_data_out  (dout),
        .bus_data_oe   (oe),
        .adc_sample_in (adc_sample),
        .out_regs      (out_regs),
        .write_pulse   (wpulse),
        .adc_busy      (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wpulse === 1'b1) pulse_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  board;
        logic [2:0]  addr;
        logic [7:0]  wdata;
        int          exp_pulses;
        logic        exp_oe;
        logic [7:0]  exp_rd;
        logic [31:0] exp_regs;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [3:0] b, input logic [2:0] a, input logic [7:0] d);
        board = b; addr = a; din = d; wr_n = 1'b0;
        tick(20);
        wr_n = 1'b1;
        tick(4);
        board = 4'h0; din = 8'h00;
        tick(1);
    endtask

    task automatic do_read(input logic [3:0] b, input logic [2:0] a, input logic eoe,
                           input logic [7:0] ed, input string tag);
        board = b; addr = a; rd_n = 1'b0;
        tick(2);
        check({tag, "_lat2_oe"}, 32'(oe), 32'h0);
        tick(1);
        check({tag, "_oe"}, 32'(oe), 32'(eoe));
        check({tag, "_data"}, 32'(dout), 32'(ed));
        rd_n = 1'b1;
        tick(3);
        check({tag, "_release_oe"}, 32'(oe), 32'h0);
        board = 4'h0;
        tick(1);
    endtask

    initial begin
        int p0;
        int busy_cnt;

        vecs[0] = '{4'h1,        3'd2, 8'h5A, 1, 1'b1, 8'h5A, 32'h005A_0000};
        vecs[1] = '{c_BOARD_ALL, 3'd3, 8'h3C, 1, 1'b1, 8'h3C, 32'h3C5A_0000};
        vecs[2] = '{4'h1,        3'd0, 8'h11, 1, 1'b1, 8'h11, 32'h3C5A_0011};
        vecs[3] = '{4'h1,        3'd4, 8'h77, 1, 1'b1, 8'h77, 32'h3C5A_0011};
        vecs[4] = '{4'h2,        3'd1, 8'h99, 0, 1'b0, 8'h00, 32'h3C5A_0011};
        vecs[5] = '{4'h1,        3'd5, 8'hEE, 1, 1'b1, 8'h00, 32'h3C5A_0011};
        vecs[6] = '{4'h3,        3'd1, 8'h42, 1, 1'b1, 8'h42, 32'h3C5A_4211};
        vecs[7] = '{4'h0,        3'd0, 8'hFF, 0, 1'b0, 8'h00, 32'h3C5A_4211};

        board = 4'h0; addr = 3'd0; rd_n = 1'b1; wr_n = 1'b1; din = 8'h00; adc_sample = 16'h0;
        tick(3);
        check("rst_oe",   32'(oe),     32'h0);
        check("rst_data", 32'(dout),   32'h0);
        check("rst_pulse",32'(wpulse), 32'h0);
        check("rst_busy", 32'(busy),   32'h0);
        check("rst_regs", out_regs,    32'h0);
        reset = 1'b0;
        p0 = pulse_cnt;
        tick(3);
        check("post_rst_pulse", pulse_cnt - p0, 32'h0);

        for (int i = 0; i < 8; i++) begin
            p0 = pulse_cnt;
            do_write(vecs[i].board, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
            check($sformatf("v%0d_regs", i), out_regs, vecs[i].exp_regs);
            do_read(vecs[i].board, vecs[i].addr, vecs[i].exp_oe, vecs[i].exp_rd,
                    $sformatf("v%0d_rd", i));
        end

        // Card-ID test cycle; RD released before WR must not turn into a write.
        p0 = pulse_cnt;
        board = 4'h1; addr = 3'd1; din = 8'hFF; rd_n = 1'b0; wr_n = 1'b0;
        tick(3);
        check("test_oe",   32'(oe),   32'h1);
        check("test_data", 32'(dout), 32'hA0);
        rd_n = 1'b1;
        tick(6);
        check("test_release_oe", 32'(oe), 32'h0);
        wr_n = 1'b1;
        tick(4);
        board = 4'h0; din = 8'h00;
        tick(1);
        check("test_no_pulse", pulse_cnt - p0, 32'h0);
        check("test_regs", out_regs, 32'h3C5A_4211);

        // Conversion length: busy high for exactly 8 clocks from the write.
        adc_sample = 16'h1234; board = 4'h1; addr = 3'd7; wr_n = 1'b0; busy_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            tick(1);
            if (busy) busy_cnt++;
            if (i == 3)  check("adc_busy_start", 32'(busy), 32'h1);
            if (i == 11) check("adc_busy_done",  32'(busy), 32'h0);
        end
        check("adc_busy_len", busy_cnt, 32'd8);
        wr_n = 1'b1;
        tick(4);
        board = 4'h0;
        tick(1);
        do_read(4'h1, 3'd5, 1'b1, 8'h34, "adc_lo");
        do_read(4'h1, 3'd6, 1'b1, 8'h12, "adc_hi");
        do_read(4'h1, 3'd7, 1'b1, 8'h00, "adc_status_idle");

        // Status and result reads during a conversion.
        adc_sample = 16'hABCD; board = 4'h1; addr = 3'd7; wr_n = 1'b0;
        tick(3);
        check("adc2_busy", 32'(busy), 32'h1);
        wr_n = 1'b1; rd_n = 1'b0;
        tick(4);
        check("status_busy_oe",   32'(oe),   32'h1);
        check("status_busy_data", 32'(dout), 32'h01);
        addr = 3'd5;
        tick(3);
        check("adc_lo_while_busy", 32'(dout), 32'h34);
        tick(2);
        check("adc_lo_after", 32'(dout), 32'hCD);
        check("adc2_idle",    32'(busy), 32'h0);
        rd_n = 1'b1;
        tick(3);
        board = 4'h0;
        tick(1);

        // Restart mid-conversion: completion moves out and captures the later sample.
        adc_sample = 16'h1111; board = 4'h1; addr = 3'd7; wr_n = 1'b0;
        tick(3);
        wr_n = 1'b1;
        tick(3);
        wr_n = 1'b0;
        tick(6);
        check("adc_restart_busy", 32'(busy), 32'h1);
        adc_sample = 16'h2222;
        tick(5);
        check("adc_restart_done", 32'(busy), 32'h0);
        wr_n = 1'b1;
        tick(4);
        board = 4'h0;
        tick(1);
        do_read(4'h1, 3'd6, 1'b1, 8'h22, "adc_restart_hi");

        // sel dropped while READ is active.
        board = 4'h1; addr = 3'd0; rd_n = 1'b0;
        tick(3);
        check("seldrop_pre_oe",   32'(oe),   32'h1);
        check("seldrop_pre_data", 32'(dout), 32'h11);
        board = 4'h0;
        tick(2);
        check("seldrop_oe_hold", 32'(oe), 32'h1);
        tick(1);
        check("seldrop_oe",   32'(oe),   32'h0);
        check("seldrop_data", 32'(dout), 32'h0);
        rd_n = 1'b1;
        tick(4);

        // Asynchronous reset in the middle of a READ.
        board = 4'h1; addr = 3'd2; rd_n = 1'b0;
        tick(4);
        check("rstmid_pre_oe",   32'(oe),   32'h1);
        check("rstmid_pre_data", 32'(dout), 32'h5A);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_oe",    32'(oe),     32'h0);
        check("rstmid_data",  32'(dout),   32'h0);
        check("rstmid_regs",  out_regs,    32'h0);
        check("rstmid_busy",  32'(busy),   32'h0);
        check("rstmid_pulse", 32'(wpulse), 32'h0);
        rd_n = 1'b1; board = 4'h0;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("rstmid_after_oe", 32'(oe), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
